// File: rtl/ahb_cfg_master_if.sv
// AHB-Lite bus bundle between the configuration loader (master) and its slave.
// Addresses are word indices; only single NONSEQ transfers are ever issued.
interface ahb_cfg_master_if;
    logic [1:0]  htrans;
    logic [11:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output htrans, haddr, hwrite, hsize, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  htrans, haddr, hwrite, hsize, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_cfg_master.sv
// Configuration loader: streams a shadow table to an AHB slave, optionally reads it
// back for comparison, then writes a trigger word. One transfer at a time, no pipelining.
module ahb_cfg_master #(
    parameter logic [11:0] ADDR_BASE = 12'h000,
    parameter int          NUM_CFG   = 10
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [31:0]       cfg_wdata,
    input  logic              start,
    input  logic              verify,
    output logic              busy,
    output logic              done,
    output logic              err,
    ahb_cfg_master_if.master  ahb
);

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HRESP_ERROR   = 2'b01;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [3:0]  LAST_IDX      = 4'(NUM_CFG - 1);
    localparam logic [11:0] TRIG_ADDR     = ADDR_BASE + 12'(NUM_CFG);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        TADDR = 3'd5,
        TDATA = 3'd6
    } state_t;

    state_t                   state, state_nxt;
    logic [3:0]               idx, idx_nxt;
    logic                     verify_q, verify_nxt;
    logic                     err_nxt;
    logic                     done_nxt;
    logic [NUM_CFG-1:0][31:0] cfg_tbl;
    logic [31:0]              tbl_rd;
    logic                     bus_err;
    logic                     rd_mismatch;
    logic                     last_idx;

    assign tbl_rd      = cfg_tbl[idx];
    assign bus_err     = ahb.hready && (ahb.hresp == HRESP_ERROR);
    assign rd_mismatch = (ahb.hrdata != tbl_rd);
    assign last_idx    = (idx == LAST_IDX);
    assign busy        = (state != IDLE);
    assign ahb.hsize   = HSIZE_WORD;

    // Shadow table is frozen while a sequence runs so the read-back compares
    // against exactly what was written.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cfg_tbl <= '0;
        end else if (cfg_we && (state == IDLE) && (cfg_idx <= LAST_IDX)) begin
            cfg_tbl[cfg_idx] <= cfg_wdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= IDLE;
            idx      <= '0;
            verify_q <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            verify_q <= verify_nxt;
            err      <= err_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        verify_nxt = verify_q;
        err_nxt    = err;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    verify_nxt = verify;
                    err_nxt    = 1'b0;
                    idx_nxt    = '0;
                    state_nxt  = WADDR;
                end
            end
            WADDR: begin
                if (ahb.hready) state_nxt = WDATA;
            end
            WDATA: begin
                if (bus_err) begin
                    err_nxt   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else if (ahb.hready) begin
                    if (!last_idx) begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = WADDR;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = verify_q ? RADDR : TADDR;
                    end
                end
            end
            RADDR: begin
                if (ahb.hready) state_nxt = RDATA;
            end
            RDATA: begin
                // A bus error and a data mismatch end the sequence the same way.
                if (bus_err || (ahb.hready && rd_mismatch)) begin
                    err_nxt   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else if (ahb.hready) begin
                    if (!last_idx) begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = RADDR;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = TADDR;
                    end
                end
            end
            TADDR: begin
                if (ahb.hready) state_nxt = TDATA;
            end
            TDATA: begin
                if (bus_err) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (ahb.hready) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus outputs decode from the registered state only, so they stay put
    // across wait states without any extra holding logic.
    always_comb begin
        ahb.htrans = HTRANS_IDLE;
        ahb.haddr  = '0;
        ahb.hwrite = 1'b0;
        ahb.hwdata = '0;
        case (state)
            WADDR: begin
                ahb.htrans = HTRANS_NONSEQ;
                ahb.hwrite = 1'b1;
                ahb.haddr  = ADDR_BASE + {8'h00, idx};
            end
            WDATA: begin
                ahb.hwdata = tbl_rd;
            end
            RADDR: begin
                ahb.htrans = HTRANS_NONSEQ;
                ahb.haddr  = ADDR_BASE + {8'h00, idx};
            end
            TADDR: begin
                ahb.htrans = HTRANS_NONSEQ;
                ahb.hwrite = 1'b1;
                ahb.haddr  = TRIG_ADDR;
            end
            TDATA: begin
                ahb.hwdata = 32'h0000_0001;
            end
            default: begin
                ahb.htrans = HTRANS_IDLE;
            end
        endcase
    end

endmodule
